// File: rtl/reg_bank_32x32.sv
// rtl/reg_bank_32x32.sv - 32x32 register storage with one write port and a sequenced bulk-clear engine.
// x0 has no storage; x1..x31 are flops feeding the Mux_32x1 read multiplexer.
module reg_bank_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done,
  output logic [DATA_WIDTH-1:0] x0,
  output logic [DATA_WIDTH-1:0] x1,
  output logic [DATA_WIDTH-1:0] x2,
  output logic [DATA_WIDTH-1:0] x3,
  output logic [DATA_WIDTH-1:0] x4,
  output logic [DATA_WIDTH-1:0] x5,
  output logic [DATA_WIDTH-1:0] x6,
  output logic [DATA_WIDTH-1:0] x7,
  output logic [DATA_WIDTH-1:0] x8,
  output logic [DATA_WIDTH-1:0] x9,
  output logic [DATA_WIDTH-1:0] x10,
  output logic [DATA_WIDTH-1:0] x11,
  output logic [DATA_WIDTH-1:0] x12,
  output logic [DATA_WIDTH-1:0] x13,
  output logic [DATA_WIDTH-1:0] x14,
  output logic [DATA_WIDTH-1:0] x15,
  output logic [DATA_WIDTH-1:0] x16,
  output logic [DATA_WIDTH-1:0] x17,
  output logic [DATA_WIDTH-1:0] x18,
  output logic [DATA_WIDTH-1:0] x19,
  output logic [DATA_WIDTH-1:0] x20,
  output logic [DATA_WIDTH-1:0] x21,
  output logic [DATA_WIDTH-1:0] x22,
  output logic [DATA_WIDTH-1:0] x23,
  output logic [DATA_WIDTH-1:0] x24,
  output logic [DATA_WIDTH-1:0] x25,
  output logic [DATA_WIDTH-1:0] x26,
  output logic [DATA_WIDTH-1:0] x27,
  output logic [DATA_WIDTH-1:0] x28,
  output logic [DATA_WIDTH-1:0] x29,
  output logic [DATA_WIDTH-1:0] x30,
  output logic [DATA_WIDTH-1:0] x31
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [4:0]            cnt_q;
  logic [4:0]            cnt_d;
  logic                  busy_q;
  logic                  clr_done_q;
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic                  wr_en;

  assign cnt_d = cnt_q + 5'd1;
  // Writes land only in IDLE (without a competing clear) or in the single DONE cycle.
  assign wr_en = we && (waddr != 5'd0) &&
                 (((state_q == IDLE) && !clr_start) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (state_q == CLEAR) begin
          if (cnt_q == 5'(i)) begin
            regs_q[i] <= '0;
          end
        end else if (wr_en && (waddr == 5'(i))) begin
          regs_q[i] <= wdata;
        end
      end
      case (state_q)
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == 5'd31) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= 5'd0;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;

  assign x0  = '0;
  assign x1  = regs_q[1];
  assign x2  = regs_q[2];
  assign x3  = regs_q[3];
  assign x4  = regs_q[4];
  assign x5  = regs_q[5];
  assign x6  = regs_q[6];
  assign x7  = regs_q[7];
  assign x8  = regs_q[8];
  assign x9  = regs_q[9];
  assign x10 = regs_q[10];
  assign x11 = regs_q[11];
  assign x12 = regs_q[12];
  assign x13 = regs_q[13];
  assign x14 = regs_q[14];
  assign x15 = regs_q[15];
  assign x16 = regs_q[16];
  assign x17 = regs_q[17];
  assign x18 = regs_q[18];
  assign x19 = regs_q[19];
  assign x20 = regs_q[20];
  assign x21 = regs_q[21];
  assign x22 = regs_q[22];
  assign x23 = regs_q[23];
  assign x24 = regs_q[24];
  assign x25 = regs_q[25];
  assign x26 = regs_q[26];
  assign x27 = regs_q[27];
  assign x28 = regs_q[28];
  assign x29 = regs_q[29];
  assign x30 = regs_q[30];
  assign x31 = regs_q[31];

endmodule

// File: tb/tb_reg_bank_32x32.sv
// tb/tb_reg_bank_32x32.sv - directed scoreboard bench for reg_bank_32x32.
module tb_reg_bank_32x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        clr_start;
  logic        busy;
  logic        clr_done;
  logic [31:0] xs [32];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];

  always #5 clk = ~clk;

  reg_bank_32x32 #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .x0(xs[0]),   .x1(xs[1]),   .x2(xs[2]),   .x3(xs[3]),
    .x4(xs[4]),   .x5(xs[5]),   .x6(xs[6]),   .x7(xs[7]),
    .x8(xs[8]),   .x9(xs[9]),   .x10(xs[10]), .x11(xs[11]),
    .x12(xs[12]), .x13(xs[13]), .x14(xs[14]), .x15(xs[15]),
    .x16(xs[16]), .x17(xs[17]), .x18(xs[18]), .x19(xs[19]),
    .x20(xs[20]), .x21(xs[21]), .x22(xs[22]), .x23(xs[23]),
    .x24(xs[24]), .x25(xs[25]), .x26(xs[26]), .x27(xs[27]),
    .x28(xs[28]), .x29(xs[29]), .x30(xs[30]), .x31(xs[31])
  );

  // Stand-in for the downstream Mux_32x1; sel 32/33 expose busy/clr_done.
  function automatic logic [31:0] observe(input int sel);
    if (sel < 32) return xs[sel];
    if (sel == 32) return {31'd0, busy};
    return {31'd0, clr_done};
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t       it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      n_cmp++;
      assert (obs === it.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_all(input string tag, input logic [31:0] ref_vals [32]);
    for (int k = 0; k < 32; k++) push($sformatf("%s_x%0d", tag, k), k, ref_vals[k]);
  endtask

  logic [31:0] model [32];
  int          busy_cnt;
  int          done_cnt;

  initial begin
    reset = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; clr_start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    push_all("reset", model);
    push("reset_busy", 32, 32'd0);
    push("reset_done", 33, 32'd0);
    drain();
    reset = 1'b0;

    // Write sweep: k*10 into register k, one per cycle, checked right after its edge.
    for (int k = 0; k < 32; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 32'(k * 10);
      if (k != 0) model[k] = 32'(k * 10);
      push($sformatf("wr_lat_x%0d", k), k, model[k]);
      tick();
      drain();
    end
    we = 1'b0;
    for (int s = 0; s < 32; s++) push($sformatf("mux_sel%0d", s), s, (s == 0) ? 32'd0 : 32'(s * 10));
    drain();

    // x0 protection.
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    push_all("x0prot", model);
    drain();

    // Load all ones, then clear with a stray write to an already-cleared register.
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 32'hFFFFFFFF;
      tick();
    end
    we = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = clr_done ? 1 : 0;
    push("clr_e0_busy", 32, 32'd1);
    push("clr_e0_x1", 1, 32'hFFFFFFFF);
    drain();
    for (int k = 1; k < 32; k++) begin
      if (k == 10) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'h00001234;
      end
      tick();
      we = 1'b0;
      busy_cnt += busy ? 1 : 0;
      done_cnt += clr_done ? 1 : 0;
      push($sformatf("clr_e%0d_x%0d", k, k), k, 32'd0);
      if (k < 31) push($sformatf("clr_e%0d_next_x%0d", k, k + 1), k + 1, 32'hFFFFFFFF);
      push($sformatf("clr_e%0d_busy", k), 32, (k < 31) ? 32'd1 : 32'd0);
      push($sformatf("clr_e%0d_done", k), 33, (k == 31) ? 32'd1 : 32'd0);
      if (k >= 10) push($sformatf("clr_e%0d_x2_nowrite", k), 2, 32'd0);
      drain();
    end
    tick();
    busy_cnt += busy ? 1 : 0;
    done_cnt += clr_done ? 1 : 0;
    check_count("clr_busy_cycles", busy_cnt, 31);
    check_count("clr_done_pulses", done_cnt, 1);
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    push_all("clr_end", model);
    push("clr_end_busy", 32, 32'd0);
    drain();

    // Collisions: clear beats write; write in DONE lands; clr_start in DONE ignored.
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000007; clr_start = 1'b1;
    tick();
    we = 1'b0; clr_start = 1'b0;
    push("col_e0_x3_dropped", 3, 32'h00000055);
    push("col_e0_busy", 32, 32'd1);
    drain();
    for (int k = 1; k < 32; k++) tick();
    push("col_done", 33, 32'd1);
    drain();
    we = 1'b1; waddr = 5'd4; wdata = 32'h00000009; clr_start = 1'b1;
    tick();
    we = 1'b0; clr_start = 1'b0;
    push("col_done_wr_x4", 4, 32'h00000009);
    push("col_x3_end", 3, 32'd0);
    push("col_idle_busy", 32, 32'd0);
    push("col_idle_done", 33, 32'd0);
    drain();
    tick();
    push("col_no_restart_busy", 32, 32'd0);
    drain();

    // Reset at the 10th edge of CLEAR.
    we = 1'b1; waddr = 5'd7; wdata = 32'h00000077;
    tick();
    waddr = 5'd20; wdata = 32'h00002020;
    tick();
    we = 1'b0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    push("mid_x7_cleared", 7, 32'd0);
    push("mid_x20_kept", 20, 32'h00002020);
    push("mid_x4_cleared", 4, 32'd0);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_all("midrst", model);
    push("midrst_busy", 32, 32'd0);
    push("midrst_done", 33, 32'd0);
    drain();
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      busy_cnt += busy ? 1 : 0;
      done_cnt += clr_done ? 1 : 0;
    end
    check_count("midrst_busy_after", busy_cnt, 0);
    check_count("midrst_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
